// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer: CTRL/PRESET/COUNT registers, IDLE-LOAD-CNT-INT sequencer,
// one-shot or auto-reload expiry interrupt. Reads are combinational from Addr[3:2].
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         ctrl;
  logic [CNT_W-1:0]   preset;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               irq_flag;
  logic               irq_nxt;
  logic               en_clr;
  logic               ctrl_wr;
  logic               preset_wr;
  logic               unused_bits;

  assign ctrl_wr     = WE && (Addr[3:2] == 2'd0);
  assign preset_wr   = WE && (Addr[3:2] == 2'd1);
  assign unused_bits = ^{Addr[31:4], Addr[1:0]};

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    irq_nxt   = irq_flag;
    en_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl[0]) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        irq_nxt   = 1'b0;
        state_nxt = CNT;
      end
      CNT: begin
        if (!ctrl[0]) begin
          state_nxt = IDLE;
        end else if (count > CNT_W'(1)) begin
          count_nxt = count - CNT_W'(1);
        end else begin
          // A preset of 0 expires exactly like a preset of 1
          count_nxt = '0;
          irq_nxt   = 1'b1;
          state_nxt = INT;
        end
      end
      INT: begin
        state_nxt = IDLE;
        if (ctrl[2:1] == 2'b01) irq_nxt = 1'b0;
        else                    en_clr  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      irq_flag <= irq_nxt;
      // A CPU write to CTRL takes priority over the one-shot Enable clear
      if (ctrl_wr)     ctrl    <= Din[3:0];
      else if (en_clr) ctrl[0] <= 1'b0;
      if (preset_wr)   preset  <= Din[CNT_W-1:0];
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      2'd0:    Dout[3:0]       = ctrl;
      2'd1:    Dout[CNT_W-1:0] = preset;
      2'd2:    Dout[CNT_W-1:0] = count;
      default: Dout            = '0;
    endcase
  end

  assign IRQ = ctrl[3] & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Randomised register-level bench for timer_counter; a timeline model predicts every read,
// a negedge monitor checks Dout/IRQ against the queued expectations.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;

  timer_counter #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dout;
    logic        irq;
    int          t;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   passes = 0;
  bit   rd = 1'b0;
  int   t = 0;

  // Reference model: either a static snapshot or a run described by its start cycle and parameters
  bit          run_active = 1'b0;
  int          run_start;
  logic [31:0] run_n;
  bit          run_m1;
  int          run_dis;
  logic [31:0] run_c0;
  bit          run_f0;
  logic [3:0]  run_ctrl;
  logic [31:0] st_c = '0;
  bit          st_f = 1'b0;
  logic [3:0]  st_ctrl = '0;
  logic [31:0] m_preset = '0;

  // Values the registers hold during cycle t. k counts edges since the enabling write:
  // k<2 old values, k=2 count=N, expiry at k=N'+2, auto-reload period N'+3.
  function automatic void cur_state(output logic [31:0] c, output bit f, output logic [3:0] ctl);
    longint n, nn, j, kk;
    c = st_c; f = st_f; ctl = st_ctrl;
    if (run_active) begin
      n  = longint'({32'b0, run_n});
      nn = (n == 0) ? 64'sd1 : n;
      kk = longint'(t - run_start);
      ctl = run_ctrl;
      if (run_dis >= 0 && kk > longint'(run_dis)) kk = longint'(run_dis);
      if (kk < 2) begin
        c = run_c0; f = run_f0;
      end else if (run_m1) begin
        j = (kk - 2) % (nn + 3);
        c = (j < n) ? 32'(n - j) : 32'd0;
        f = (j == nn);
      end else if (kk - 2 >= nn) begin
        c = '0; f = 1'b1;
        if (run_dis < 0 && kk >= nn + 3) ctl[0] = 1'b0;
      end else begin
        c = 32'(n - (kk - 2)); f = 1'b0;
      end
    end
  endfunction

  function automatic bit run_done();
    longint nn, k;
    if (!run_active) return 1'b1;
    nn = longint'({32'b0, run_n});
    if (nn == 0) nn = 1;
    k = longint'(t - run_start);
    if (run_dis >= 0) return k >= longint'(run_dis) + 1;
    if (run_m1) return 1'b0;
    return k >= nn + 3;
  endfunction

  function automatic void apply_write(input int a, input logic [31:0] d);
    if (a == 0) begin
      if (run_active && run_done()) begin
        cur_state(st_c, st_f, st_ctrl);
        run_active = 1'b0;
      end
      if (run_active) begin
        if (!d[0]) begin
          run_dis  = t - run_start;
          run_ctrl = d[3:0];
        end
      end else if (d[0]) begin
        run_active = 1'b1;
        run_start  = t;
        run_n      = m_preset;
        run_m1     = (d[2:1] == 2'b01);
        run_dis    = -1;
        run_c0     = st_c;
        run_f0     = st_f;
        run_ctrl   = d[3:0];
      end else begin
        st_ctrl = d[3:0];
      end
    end else if (a == 1) begin
      m_preset = d;
    end
  endfunction

  task automatic cycle(input bit we_i, input int a_i, input logic [31:0] d_i);
    logic [31:0] c;
    bit          f;
    logic [3:0]  ctl;
    exp_t        e;
    int          a;
    cur_state(c, f, ctl);
    a = (a_i < 0) ? int'($urandom_range(0, 3)) : a_i;
    case (a)
      0:       e.dout = {28'b0, ctl};
      1:       e.dout = m_preset;
      2:       e.dout = c;
      default: e.dout = '0;
    endcase
    e.addr = (($urandom_range(0, 1) != 0) ? 32'h7f10 : 32'h7f00) | 32'(a * 4);
    e.irq  = ctl[3] & f;
    e.t    = t;
    sb.push_back(e);
    Addr = e.addr; WE = we_i; Din = d_i; rd = 1'b1;
    @(posedge clk); #1;
    t++;
    WE = 1'b0;
    if (we_i) apply_write(a, d_i);
  endtask

  task automatic idle();
    if ($urandom_range(0, 7) == 0) cycle(1'b1, 2 + int'($urandom_range(0, 1)), $urandom);
    else                           cycle(1'b0, -1, 32'd0);
  endtask

  // Asserted between edges so the monitor sees the cleared outputs before any clock
  task automatic do_reset();
    exp_t e;
    Addr = 32'h7f08; WE = 1'b0; reset_n = 1'b0;
    e.addr = Addr; e.dout = '0; e.irq = 1'b0; e.t = t;
    sb.push_back(e);
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0; t++;
    @(posedge clk); #1;
    reset_n = 1'b1; t++;
    run_active = 1'b0; st_c = '0; st_f = 1'b0; st_ctrl = '0; m_preset = '0;
  endtask

  always @(negedge clk) begin
    if (rd) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL read: no expectation queued, got dout=%h irq=%b", Dout, IRQ);
      end else begin
        me = sb.pop_front();
        if (Dout === me.dout && IRQ === me.irq) passes++;
        else $display("FAIL read t=%0d addr=%h: got dout=%h irq=%b, expected dout=%h irq=%b",
                      me.t, me.addr, Dout, IRQ, me.dout, me.irq);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] n1, n2, r;
    logic [1:0]  mode;
    bit          im, im2, im3, mask;
    int          dis, kp, len, len2;
    longint      nn1;
    @(posedge clk); #1;
    for (int it = 0; it < 12; it++) begin
      do_reset();
      for (int a = 0; a < 4; a++) cycle(1'b0, a, 32'd0);
      n1   = $urandom_range(0, 9);
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      nn1  = (n1 == 0) ? 64'sd1 : longint'({32'b0, n1});
      dis  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 32'(nn1 + 1))) : -1;
      kp   = (mode != 2'b01 && $urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : -1;
      n2   = $urandom_range(0, 9);
      mask = 1'($urandom_range(0, 1));
      im2  = 1'($urandom_range(0, 1));
      im3  = 1'($urandom_range(0, 1));
      case (it)
        0: begin n1 = 5; mode = 2'b00; im = 1'b1; dis = -1; kp = -1; mask = 1'b0; im3 = 1'b1; end
        1: begin n1 = 3; mode = 2'b01; im = 1'b1; dis = -1; kp = -1; end
        2: begin n1 = 32'hffff_ffff; mode = 2'b00; im = 1'b1; dis = 10; kp = -1; end
        3: begin n1 = 4; mode = 2'b00; im = 1'b0; dis = -1; kp = -1; mask = 1'b1; im2 = 1'b1; im3 = 1'b1; end
        4: begin n1 = 12; mode = 2'b00; im = 1'b1; dis = 4; kp = -1; mask = 1'b0; im3 = 1'b1; end
        5: begin n1 = 6; mode = 2'b00; im = 1'b1; dis = -1; kp = 3; n2 = 100; mask = 1'b0; im3 = 1'b1; end
        default: ;
      endcase
      nn1 = (n1 == 0) ? 64'sd1 : longint'({32'b0, n1});
      if (kp == dis - 1) kp = -1;
      r = $urandom;
      cycle(1'b1, 1, n1);
      cycle(1'b1, 0, {r[27:0], im, mode, 1'b1});
      if (mode == 2'b01 && dis < 0) len = int'(3 * (nn1 + 3) + 3);
      else len = ((dis >= 0) ? dis + 2 : int'(nn1) + 4) + int'($urandom_range(0, 2));
      for (int k = 0; k < len; k++) begin
        r = $urandom;
        if (k == dis - 1)  cycle(1'b1, 0, {r[27:0], im, mode, 1'b0});
        else if (k == kp)  cycle(1'b1, 1, n2);
        else               idle();
      end
      if (mode == 2'b01 && dis < 0) continue;
      r = $urandom;
      if (mask) begin
        cycle(1'b1, 0, {r[27:0], im2, mode, 1'b0});
        for (int k = 0; k < 3; k++) idle();
      end
      cycle(1'b1, 0, {r[31:4], im3, 2'b00, 1'b1});
      len2 = int'($urandom_range(1, (m_preset > 200) ? 20 : m_preset + 6));
      for (int k = 0; k < len2; k++) idle();
    end
    rd = 1'b0;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL drain: got %0d unchecked expectations, required 0", sb.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped 32-bit down-counting timer on the Bridge's device side.
- One instance serves the TC0 window (0x7f00–0x7f0b) and a second serves the TC1 window (0x7f10–0x7f1b).
- The Bridge has already decoded the window, so this block receives `DevAddr`, a single-bit write enable (OR of byte enables) and `DevWD`, and returns read data.
- Its `IRQ` output feeds the CP0 hardware-interrupt inputs.

Parameters:
- CNT_W, 32, width of PRESET/COUNT. `Din`/`Dout` bits above CNT_W are truncated on write and read as 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Addr  in  32  device address from the Bridge. Only Addr[3:2] is decoded.
- WE  in  1  write strobe, already qualified by the Bridge window select.
- Din  in  32  write data.
- Dout  out  32  read data, combinational from Addr[3:2].
- IRQ  out  1  interrupt request = ctrl[3] & irq_flag.

Behaviour:
- Reset behaviour:
  - Interface is one clock; reset is asynchronous and active-low.
  - On reset: ctrl=0, preset=0, count=0, irq_flag=0, state=IDLE. Therefore IRQ=0, and Dout is 0 for every address.
  - Reset mid-count takes effect immediately, with no pending IRQ.
- Register map (Addr[3:2]):
  - 0 CTRL, r/w. Bit [3]=IM (interrupt mask enable), bits [2:1]=Mode, bit [0]=Enable. Bits [31:4] read 0.
  - 1 PRESET, r/w.
  - 2 COUNT, read-only; writes are ignored.
  - 3 reads 0; writes are ignored.
- Writes:
  - A write with WE=1 updates the register at the clock edge. The new value is visible to Dout and to the FSM in the next cycle.
  - If a CPU write to CTRL coincides with the FSM clearing Enable, the CPU write wins.
- FSM states: IDLE, LOAD, CNT, INT. All transitions occur at the clock edge.
  - IDLE: if Enable=1, go to LOAD; otherwise stay.
  - LOAD: count<=preset, irq_flag<=0, go to CNT.
  - CNT:
    - if Enable=0, go to IDLE with count frozen;
    - else if count>1, count<=count-1;
    - else (count is 0 or 1), count<=0, irq_flag<=1, go to INT.
  - INT: go to IDLE. Then:
    - Mode 0 (one-shot; Mode 2 and 3 behave as Mode 0): ctrl[0]<=0. irq_flag stays 1 until the next LOAD.
    - Mode 1 (auto-reload): irq_flag<=0. Since Enable is still 1, the timer restarts via IDLE→LOAD.
- Timing:
  - Preset N≥1, Enable written at edge E0: LOAD at E1, count=N after E2, count=0 and IRQ high after edge E(N+2).
  - N=0 behaves as N=1.
  - Mode 1: IRQ is high for exactly 1 cycle with period N+3 cycles.
- Mid-count register writes:
  - A PRESET write mid-count does not disturb count; it applies at the next LOAD.
  - Clearing IM mid-count masks IRQ but irq_flag is retained. Setting IM again re-exposes a pending flag.
  - Writing Enable=0 in INT: the Mode-0 clear is redundant; the Mode-1 restart is suppressed (IDLE holds).
- Count arithmetic: CNT_W-bit unsigned, never wraps below 0. preset=0xFFFFFFFF counts the full range without overflow.

Test Plan:
- Reset, then read each of Addr 0x7f00/04/08/0c → all read 0, IRQ=0. Assert reset_n low mid-count → count=0, IRQ=0 asynchronously.
- PRESET=5, then CTRL=0x9 (IM=1, Mode 0, En=1) → COUNT reads 5,4,3,2,1,0 on successive cycles starting 2 cycles after the write. IRQ rises N+2=7 cycles after the write edge and stays high. CTRL then reads 0x8.
- PRESET=3, CTRL=0xB (Mode 1) → IRQ is a 1-cycle pulse every 6 cycles for ≥3 periods. COUNT reloads to 3 each period.
- In Mode 0 with COUNT=10, write CTRL=0x8 (En=0) → COUNT freezes at the next value with no IRQ. Re-write 0x9 → reload from PRESET.
- In Mode 0, write PRESET=100 mid-count → current run expires at the old preset. The next enable counts from 100.
- CTRL=0x1 (IM=0) run to expiry → IRQ stays 0, irq_flag is set. Write CTRL=0x8 → IRQ goes to 1 the next cycle. Write CTRL=0x9 → LOAD clears the flag and IRQ falls.
